// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage slice: default widths,
// the ID->EX payload bundle and a small helper for load visibility.
package cpu_pipe_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_REG_NUM    = 32;
  localparam int DEF_CTRL_WIDTH = 16;
  localparam int REG_ADDR_W     = $clog2(DEF_REG_NUM);
  localparam int SHADOW_W       = 3;

  // Payload carried from ID into EX, at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0] rs1_data;
    logic [DEF_DATA_WIDTH-1:0] rs2_data;
    logic [DEF_DATA_WIDTH-1:0] rs3_data;
    logic [DEF_DATA_WIDTH-1:0] imm;
    logic [REG_ADDR_W-1:0]     rd_addr;
    logic                      rd_we;
    logic                      is_load;
    logic [DEF_CTRL_WIDTH-1:0] ctrl;
  } id_ex_payload_t;

  // A load only matters to the hazard detector when it really writes a
  // non-x0 register from a valid EX slot.
  function automatic logic load_visible(input logic valid, input logic is_ld,
                                        input logic rd_we, input logic rd_nonzero);
    return valid & is_ld & rd_we & rd_nonzero;
  endfunction

endpackage

// File: rtl/stage_hazard_shadow_ctr.sv
// Load-use shadow counter: stretches a single-cycle load_stall into
// LOAD_SHADOW bubbles and produces the combined bubble request.
module stage_hazard_shadow_ctr
  import cpu_pipe_pkg::*;
#(
  parameter int LOAD_SHADOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_stall,
  input  logic flush,
  input  logic ex_stall,
  output logic bubble_req
);

  localparam logic [SHADOW_W-1:0] SHADOW_INIT = SHADOW_W'(LOAD_SHADOW - 1);
  localparam logic [SHADOW_W-1:0] SHADOW_ZERO = {SHADOW_W{1'b0}};
  localparam logic [SHADOW_W-1:0] SHADOW_ONE  = {{(SHADOW_W-1){1'b0}}, 1'b1};

  logic [SHADOW_W-1:0] r_cnt;

  // Counter: cleared by reset/flush, frozen by EX backpressure, armed on a new hazard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= SHADOW_ZERO;
    end else if (flush) begin
      r_cnt <= SHADOW_ZERO;
    end else if (ex_stall) begin
      r_cnt <= r_cnt;
    end else if (r_cnt != SHADOW_ZERO) begin
      r_cnt <= r_cnt - SHADOW_ONE;
    end else if (load_stall) begin
      r_cnt <= SHADOW_INIT;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign bubble_req = load_stall | (r_cnt != SHADOW_ZERO);

endmodule

// File: rtl/stage_id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX backpressure
// and flush. Optional bubble performance counter under STAGE_ID_EX_PERF_EN.
module stage_id_ex_reg
  import cpu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int REG_NUM     = DEF_REG_NUM,
  parameter int CTRL_WIDTH  = DEF_CTRL_WIDTH,
  parameter int LOAD_SHADOW = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [ADDR_WIDTH-1:0]      id_pc,
  input  logic [DATA_WIDTH-1:0]      id_rs1_data,
  input  logic [DATA_WIDTH-1:0]      id_rs2_data,
  input  logic [DATA_WIDTH-1:0]      id_rs3_data,
  input  logic [DATA_WIDTH-1:0]      id_imm,
  input  logic [$clog2(REG_NUM)-1:0] id_rd_addr,
  input  logic                       id_rd_we,
  input  logic                       id_is_load,
  input  logic [CTRL_WIDTH-1:0]      id_ctrl,
  input  logic                       load_stall,
  input  logic                       flush,
  input  logic                       ex_stall,
  output logic                       id_ready,
  output logic                       ex_valid,
  output logic [ADDR_WIDTH-1:0]      ex_pc,
  output logic [DATA_WIDTH-1:0]      ex_rs1_data,
  output logic [DATA_WIDTH-1:0]      ex_rs2_data,
  output logic [DATA_WIDTH-1:0]      ex_rs3_data,
  output logic [DATA_WIDTH-1:0]      ex_imm,
  output logic [$clog2(REG_NUM)-1:0] ex_rd_addr,
  output logic                       ex_rd_we,
  output logic                       ex_is_load,
  output logic [CTRL_WIDTH-1:0]      ex_ctrl,
  output logic [$clog2(REG_NUM)-1:0] load_rd,
  output logic                       is_load
`ifdef STAGE_ID_EX_PERF_EN
  ,
  output logic [31:0]                bubble_cnt
`endif
);

  localparam int RA_W = $clog2(REG_NUM);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] rs3_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [RA_W-1:0]       rd_addr;
    logic                  rd_we;
    logic                  is_load;
    logic [CTRL_WIDTH-1:0] ctrl;
  } payload_t;

  logic     w_bubble_req;
  payload_t w_id_pay;
  payload_t r_pay;
  logic     r_valid;

  stage_hazard_shadow_ctr #(
    .LOAD_SHADOW(LOAD_SHADOW)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_stall(load_stall),
    .flush     (flush),
    .ex_stall  (ex_stall),
    .bubble_req(w_bubble_req)
  );

  assign id_ready = ~ex_stall & ~w_bubble_req;

  // Incoming payload; write-enable and load flag only survive with a valid instruction.
  always_comb begin
    w_id_pay          = {$bits(payload_t){1'b0}};
    w_id_pay.pc       = id_pc;
    w_id_pay.rs1_data = id_rs1_data;
    w_id_pay.rs2_data = id_rs2_data;
    w_id_pay.rs3_data = id_rs3_data;
    w_id_pay.imm      = id_imm;
    w_id_pay.rd_addr  = id_rd_addr;
    w_id_pay.rd_we    = id_rd_we & id_valid;
    w_id_pay.is_load  = id_is_load & id_valid;
    w_id_pay.ctrl     = id_ctrl;
  end

  // EX register: reset > flush > hold > bubble (data held) > normal advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pay   <= {$bits(payload_t){1'b0}};
    end else if (flush) begin
      r_valid       <= 1'b0;
      r_pay.rd_we   <= 1'b0;
      r_pay.is_load <= 1'b0;
    end else if (ex_stall) begin
      r_valid <= r_valid;
      r_pay   <= r_pay;
    end else if (w_bubble_req && id_valid) begin
      r_valid       <= 1'b0;
      r_pay.rd_we   <= 1'b0;
      r_pay.is_load <= 1'b0;
    end else begin
      r_valid <= id_valid;
      r_pay   <= w_id_pay;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pay.pc;
  assign ex_rs1_data = r_pay.rs1_data;
  assign ex_rs2_data = r_pay.rs2_data;
  assign ex_rs3_data = r_pay.rs3_data;
  assign ex_imm      = r_pay.imm;
  assign ex_rd_addr  = r_pay.rd_addr;
  assign ex_rd_we    = r_pay.rd_we;
  assign ex_is_load  = r_pay.is_load;
  assign ex_ctrl     = r_pay.ctrl;
  assign load_rd     = r_pay.rd_addr;
  assign is_load     = load_visible(r_valid, r_pay.is_load, r_pay.rd_we,
                                    r_pay.rd_addr != {RA_W{1'b0}});

`ifdef STAGE_ID_EX_PERF_EN
  logic        w_bubble_slot;
  logic [31:0] r_bubble_cnt;

  assign w_bubble_slot = ~flush & ~ex_stall & w_bubble_req & id_valid;

  // Saturating count of bubbles actually inserted into EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_bubble_slot && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_stage_id_ex_reg.sv
// Scoreboard bench for stage_id_ex_reg: directed hazard/stall/flush
// sequences followed by randomized traffic, checked against a cycle
// reference model of the stage rules. Honours STAGE_ID_EX_PERF_EN.
module tb_stage_id_ex_reg;
  import cpu_pipe_pkg::*;

  localparam int TB_SHADOW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, id_valid, id_rd_we, id_is_load, load_stall, flush, ex_stall;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_rs3_data, id_imm;
  logic [4:0]  id_rd_addr;
  logic [15:0] id_ctrl;

  logic        id_ready, ex_valid, ex_rd_we, ex_is_load, is_load;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_rs3_data, ex_imm;
  logic [4:0]  ex_rd_addr, load_rd;
  logic [15:0] ex_ctrl;
`ifdef STAGE_ID_EX_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  stage_id_ex_reg #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_NUM(32), .CTRL_WIDTH(16),
    .LOAD_SHADOW(TB_SHADOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs3_data(id_rs3_data),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_ctrl(id_ctrl), .load_stall(load_stall),
    .flush(flush), .ex_stall(ex_stall), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs3_data(ex_rs3_data), .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
    .load_rd(load_rd), .is_load(is_load)
`ifdef STAGE_ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic           valid;
    id_ex_payload_t pay;
    logic           isl;
    logic           rdy;
    logic [31:0]    bub;
  } exp_t;

  exp_t           sb[$];
  logic           m_valid;
  id_ex_payload_t m_pay;
  int             m_shadow;
  longint         m_bub;
  int             n_cmp  = 0;
  int             n_fail = 0;

  // Reference model: advance the expected EX contents by one clock using
  // the inputs that were presented before the edge.
  task automatic model_tick();
    bit bubble;
    bubble = load_stall || (m_shadow > 0);
    if (!rst_n) begin
      m_valid = 1'b0; m_pay = '0; m_shadow = 0; m_bub = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_pay.rd_we = 1'b0; m_pay.is_load = 1'b0; m_shadow = 0;
    end else if (!ex_stall) begin
      if (bubble && id_valid) begin
        m_valid = 1'b0; m_pay.rd_we = 1'b0; m_pay.is_load = 1'b0;
        if (m_bub < 64'hFFFF_FFFF) m_bub = m_bub + 1;
      end else begin
        m_valid        = id_valid;
        m_pay.pc       = id_pc;
        m_pay.rs1_data = id_rs1_data;
        m_pay.rs2_data = id_rs2_data;
        m_pay.rs3_data = id_rs3_data;
        m_pay.imm      = id_imm;
        m_pay.rd_addr  = id_rd_addr;
        m_pay.rd_we    = id_valid && id_rd_we;
        m_pay.is_load  = id_valid && id_is_load;
        m_pay.ctrl     = id_ctrl;
      end
      if (m_shadow > 0) m_shadow = m_shadow - 1;
      else if (load_stall) m_shadow = TB_SHADOW - 1;
    end
  endtask

  // One clock: update the model, drive the next inputs, queue the expectation.
  task automatic step(input bit rst, input bit vld, input logic [63:0] pc,
                      input bit ld, input logic [4:0] rd, input bit we,
                      input bit ls, input bit fl, input bit st);
    exp_t e;
    @(posedge clk);
    #1;
    model_tick();
    rst_n = rst; id_valid = vld; id_pc = pc; id_is_load = ld; id_rd_addr = rd;
    id_rd_we = we; load_stall = ls; flush = fl; ex_stall = st;
    id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
    id_rs3_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_ctrl = 16'($urandom);
    e.valid = m_valid;
    e.pay   = m_pay;
    e.isl   = m_valid && m_pay.is_load && m_pay.rd_we && (m_pay.rd_addr != 5'd0);
    e.rdy   = !st && !(ls || (m_shadow > 0));
    e.bub   = m_bub[31:0];
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: whenever an expectation is pending, compare the DUT outputs mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_valid",   64'(ex_valid),    64'(e.valid));
      chk("id_ready",   64'(id_ready),    64'(e.rdy));
      chk("is_load",    64'(is_load),     64'(e.isl));
      chk("load_rd",    64'(load_rd),     64'(e.pay.rd_addr));
      chk("ex_pc",      ex_pc,            e.pay.pc);
      chk("ex_rs1",     ex_rs1_data,      e.pay.rs1_data);
      chk("ex_rs2",     ex_rs2_data,      e.pay.rs2_data);
      chk("ex_rs3",     ex_rs3_data,      e.pay.rs3_data);
      chk("ex_imm",     ex_imm,           e.pay.imm);
      chk("ex_rd_addr", 64'(ex_rd_addr),  64'(e.pay.rd_addr));
      chk("ex_rd_we",   64'(ex_rd_we),    64'(e.pay.rd_we));
      chk("ex_is_load", 64'(ex_is_load),  64'(e.pay.is_load));
      chk("ex_ctrl",    64'(ex_ctrl),     64'(e.pay.ctrl));
`ifdef STAGE_ID_EX_PERF_EN
      chk("bubble_cnt", 64'(bubble_cnt),  64'(e.bub));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; id_pc = 64'h1000; id_is_load = 1'b0;
    id_rd_addr = 5'd0; id_rd_we = 1'b0; load_stall = 1'b0; flush = 1'b0;
    ex_stall = 1'b0; id_rs1_data = 64'd0; id_rs2_data = 64'd0;
    id_rs3_data = 64'd0; id_imm = 64'd0; id_ctrl = 16'd0;
    m_valid = 1'b0; m_pay = '0; m_shadow = 0; m_bub = 0;

    // Reset held with a valid instruction waiting in ID.
    step(1'b0, 1'b1, 64'h1000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Release: 0x1000 advances; then a load to x5.
    step(1'b1, 1'b1, 64'h1000, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h1004, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    // Consumer of x5 meets load_stall for one cycle; shadow stretches it.
    step(1'b1, 1'b1, 64'h1008, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 64'h1008, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    // Load to x7 enters EX, then backpressure with load_stall for 4 cycles.
    step(1'b1, 1'b1, 64'h100C, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 64'h1010, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'h1010, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 64'h1010, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    // Valid load in EX, then flush together with ex_stall.
    step(1'b1, 1'b1, 64'h1014, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h1018, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 64'h1018, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    // Load targeting x0 must not look like a load to the detector.
    step(1'b1, 1'b1, 64'h101C, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h1020, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset in the middle of a shadow.
    step(1'b1, 1'b1, 64'h1024, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h1028, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 64'h102C, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           {$urandom, $urandom}, 1'($urandom), rd, 1'($urandom),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 20);
    end

    // Let the monitor consume the last expectation, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
